// File: rtl/binge_log_if.sv
// binge_log_if: record handshake between binge_log and the host.
//   rec_valid : record FIFO holds at least one record
//   rec_data  : head record {partial, person[2:0], duration[6:0], pass[1:0]}
//   rec_ready : host accepts the head record this cycle
// The master side belongs to binge_log. The slave side belongs to the host.
interface binge_log_if;
  logic        rec_valid;
  logic [12:0] rec_data;
  logic        rec_ready;

  modport master (output rec_valid, output rec_data, input rec_ready);
  modport slave  (input rec_valid, input rec_data, output rec_ready);
endinterface

// File: rtl/binge_log.sv
// binge_log: watches the viewer tracker status word and logs completed runs.
// It samples {person, week, finished, state} every cycle and detects two events:
//   - season start: NS -> S1
//   - completion: entry into F
// Each completed run is timed in weeks and queued as a record for the host.
// Ports:
//   clk, rst_n  : clock and asynchronous active-low reset
//   status_in   : {person[2:0], week[6:0], finished[1:0], state[2:0]}
//   rec         : record handshake (master modport)
//   comp_count  : saturating count of completions seen
//   overflow    : sticky flag, set when a record is dropped on a full FIFO
module binge_log #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [14:0]      status_in,
  binge_log_if.master      rec,
  output logic [7:0]       comp_count,
  output logic             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    ST_NS  = 3'd0,
    ST_S1  = 3'd1,
    ST_F   = 3'd6
  } view_state_e;

  logic [2:0]  cur_person;
  logic [6:0]  cur_week;
  logic [1:0]  cur_fin;
  logic [2:0]  cur_state;

  logic [2:0]  prev_state_q, prev_state_d;
  logic [2:0]  prev_person_q, prev_person_d;
  logic        prev_ok_q, prev_ok_d;
  logic [6:0]  start_week_q, start_week_d;
  logic        start_ok_q, start_ok_d;
  logic [7:0]  comp_count_q, comp_count_d;
  logic        overflow_q, overflow_d;

  logic [12:0] mem_q [DEPTH];
  logic [12:0] mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic        same_person;
  logic        person_chg;
  logic        start_ev;
  logic        comp_ev;
  logic        pop;
  logic        full;
  logic        push_ok;
  logic [6:0]  duration;
  logic [12:0] new_rec;

  assign cur_person = status_in[14:12];
  assign cur_week   = status_in[11:5];
  assign cur_fin    = status_in[4:3];
  assign cur_state  = status_in[2:0];

  // Event decode. Nothing fires until one sample has primed prev_*.
  // A person change suppresses both events for that cycle.
  assign same_person = (cur_person == prev_person_q);
  assign person_chg  = prev_ok_q & ~same_person;
  assign start_ev    = prev_ok_q & same_person &
                       (prev_state_q == ST_NS) & (cur_state == ST_S1);
  assign comp_ev     = prev_ok_q & same_person &
                       (cur_state == ST_F) & (prev_state_q != ST_F);

  // A run with no observed start is logged as partial with zero duration.
  // The subtraction wraps modulo 128 to cover week rollover.
  assign duration = start_ok_q ? (cur_week - start_week_q) : 7'd0;
  assign new_rec  = {~start_ok_q, cur_person, duration, cur_fin};

  // A full FIFO still accepts a push when a pop happens on the same edge.
  assign full    = (count_q == FULL_CNT);
  assign pop     = (count_q != '0) & rec.rec_ready;
  assign push_ok = comp_ev & (~full | pop);

  assign rec.rec_valid = (count_q != '0);
  assign rec.rec_data  = (count_q != '0) ? mem_q[rd_ptr_q] : 13'd0;
  assign comp_count    = comp_count_q;
  assign overflow      = overflow_q;

  // Next-state logic for the tracker registers, the counters and the FIFO.
  always_comb begin
    prev_state_d  = cur_state;
    prev_person_d = cur_person;
    prev_ok_d     = 1'b1;
    start_week_d  = start_week_q;
    start_ok_d    = start_ok_q;
    comp_count_d  = comp_count_q;
    overflow_d    = overflow_q;
    mem_d         = mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;

    if (person_chg) begin
      start_ok_d = 1'b0;
    end
    if (start_ev) begin
      start_week_d = cur_week;
      start_ok_d   = 1'b1;
    end
    if (comp_ev) begin
      start_ok_d = 1'b0;
      if (comp_count_q != 8'hFF) begin
        comp_count_d = comp_count_q + 8'd1;
      end
      if (full & ~pop) begin
        overflow_d = 1'b1;
      end
    end

    if (push_ok) begin
      mem_d[wr_ptr_q] = new_rec;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (push_ok & ~pop) begin
      count_d = count_q + 1'b1;
    end else if (pop & ~push_ok) begin
      count_d = count_q - 1'b1;
    end
  end

  // State registers, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_state_q  <= '0;
      prev_person_q <= '0;
      prev_ok_q     <= 1'b0;
      start_week_q  <= '0;
      start_ok_q    <= 1'b0;
      comp_count_q  <= '0;
      overflow_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      prev_state_q  <= prev_state_d;
      prev_person_q <= prev_person_d;
      prev_ok_q     <= prev_ok_d;
      start_week_q  <= start_week_d;
      start_ok_q    <= start_ok_d;
      comp_count_q  <= comp_count_d;
      overflow_q    <= overflow_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      mem_q         <= mem_d;
    end
  end

endmodule

// File: tb/tb_binge_log.sv
// tb_binge_log: directed testbench for binge_log with hand-computed records.
// It covers reset, a basic run, week wrap, person change, overflow, and a full FIFO
// taking a push and a pop together. It ends with an asynchronous reset mid-drain.
module tb_binge_log;

  logic        clk;
  logic        rst_n;
  logic [14:0] status_in;
  logic [7:0]  comp_count;
  logic        overflow;
  int          compared;
  int          mismatched;
  logic [12:0] exp_rec [5];

  binge_log_if rec_if ();

  binge_log #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .status_in  (status_in),
    .rec        (rec_if),
    .comp_count (comp_count),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Builds a record {partial, person, duration, pass}.
  function automatic logic [12:0] mkRec(input logic partial, input logic [2:0] person,
                                        input logic [6:0] dur, input logic [1:0] pass);
    return {partial, person, dur, pass};
  endfunction

  // Counts one comparison and reports it if the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Drives one status word and moves to 1 time unit after the sampling edge.
  task automatic applyStimulus(input logic [2:0] p, input logic [6:0] w,
                               input logic [1:0] f, input logic [2:0] s);
    status_in = {p, w, f, s};
    @(posedge clk);
    #1;
  endtask

  // Holds the current inputs for one clock.
  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  // Drives NS, then S1, then F after dur weeks. rec_ready is set to ready_f for the F cycle.
  task automatic runCompletion(input logic [2:0] p, input logic [6:0] base,
                               input logic [6:0] dur, input logic [1:0] fin,
                               input logic ready_f);
    applyStimulus(p, base, 2'd0, 3'd0);
    applyStimulus(p, 7'(base + 7'd1), 2'd0, 3'd1);
    rec_if.rec_ready = ready_f;
    applyStimulus(p, 7'(base + 7'd1 + dur), fin, 3'd6);
  endtask

  // Pulses reset and releases it on a falling edge.
  task automatic doReset();
    rst_n = 1'b0;
    rec_if.rec_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    rec_if.rec_ready = 1'b0;
    status_in  = 15'($urandom);

    // Reset holds every output at zero.
    #3;
    checkOutput("reset_valid", 32'(rec_if.rec_valid), 32'd0);
    checkOutput("reset_data", 32'(rec_if.rec_data), 32'd0);
    checkOutput("reset_count", 32'(comp_count), 32'd0);
    checkOutput("reset_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // A constant F word primes the tracker and raises no events.
    applyStimulus(3'd0, 7'd3, 2'd0, 3'd6);
    applyStimulus(3'd0, 7'd3, 2'd0, 3'd6);
    applyStimulus(3'd0, 7'd3, 2'd0, 3'd6);
    checkOutput("const_valid", 32'(rec_if.rec_valid), 32'd0);
    checkOutput("const_count", 32'(comp_count), 32'd0);

    // Basic run for person 1: start at week 10, finish at week 17.
    applyStimulus(3'd1, 7'd9, 2'd0, 3'd0);
    applyStimulus(3'd1, 7'd10, 2'd0, 3'd1);
    applyStimulus(3'd1, 7'd11, 2'd0, 3'd2);
    applyStimulus(3'd1, 7'd12, 2'd0, 3'd3);
    applyStimulus(3'd1, 7'd14, 2'd0, 3'd4);
    applyStimulus(3'd1, 7'd16, 2'd0, 3'd5);
    checkOutput("basic_pre_valid", 32'(rec_if.rec_valid), 32'd0);
    applyStimulus(3'd1, 7'd17, 2'd0, 3'd6);
    checkOutput("basic_valid", 32'(rec_if.rec_valid), 32'd1);
    checkOutput("basic_rec", 32'(rec_if.rec_data), 32'(mkRec(1'b0, 3'd1, 7'd7, 2'd0)));
    checkOutput("basic_count", 32'(comp_count), 32'd1);
    for (int i = 0; i < 5; i++) waitCycle();
    checkOutput("holdF_count", 32'(comp_count), 32'd1);
    checkOutput("holdF_rec", 32'(rec_if.rec_data), 32'(mkRec(1'b0, 3'd1, 7'd7, 2'd0)));
    rec_if.rec_ready = 1'b1;
    waitCycle();
    rec_if.rec_ready = 1'b0;
    checkOutput("basic_drained", 32'(rec_if.rec_valid), 32'd0);
    checkOutput("empty_data", 32'(rec_if.rec_data), 32'd0);

    // Week wrap: start at week 125, finish at week 4, duration 7.
    applyStimulus(3'd1, 7'd124, 2'd0, 3'd0);
    applyStimulus(3'd1, 7'd125, 2'd0, 3'd1);
    applyStimulus(3'd1, 7'd127, 2'd0, 3'd2);
    applyStimulus(3'd1, 7'd1, 2'd0, 3'd3);
    applyStimulus(3'd1, 7'd4, 2'd2, 3'd6);
    checkOutput("wrap_rec", 32'(rec_if.rec_data), 32'(mkRec(1'b0, 3'd1, 7'd7, 2'd2)));
    checkOutput("wrap_count", 32'(comp_count), 32'd2);
    rec_if.rec_ready = 1'b1;
    waitCycle();
    rec_if.rec_ready = 1'b0;

    // Person change mid-run gives a partial record with zero duration.
    applyStimulus(3'd2, 7'd20, 2'd0, 3'd3);
    applyStimulus(3'd2, 7'd21, 2'd0, 3'd3);
    applyStimulus(3'd3, 7'd22, 2'd0, 3'd4);
    checkOutput("pchg_no_event", 32'(rec_if.rec_valid), 32'd0);
    applyStimulus(3'd3, 7'd23, 2'd1, 3'd6);
    checkOutput("pchg_rec", 32'(rec_if.rec_data), 32'(mkRec(1'b1, 3'd3, 7'd0, 2'd1)));
    checkOutput("pchg_count", 32'(comp_count), 32'd3);

    // Overflow: five completions into a four-entry FIFO while the host stalls.
    doReset();
    for (int i = 0; i < 5; i++) begin
      exp_rec[i] = mkRec(1'b0, 3'd4, 7'(i + 2), 2'(i));
      runCompletion(3'd4, 7'(10 * i), 7'(i + 2), 2'(i), 1'b0);
      if (i == 3) checkOutput("ovf_not_yet", 32'(overflow), 32'd0);
    end
    checkOutput("ovf_flag", 32'(overflow), 32'd1);
    checkOutput("ovf_count", 32'(comp_count), 32'd5);
    rec_if.rec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("ovf_drain%0d", i), 32'(rec_if.rec_data), 32'(exp_rec[i]));
      waitCycle();
    end
    checkOutput("ovf_empty", 32'(rec_if.rec_valid), 32'd0);
    checkOutput("ovf_sticky", 32'(overflow), 32'd1);

    // Full FIFO: a completion and a pop on the same edge.
    doReset();
    for (int i = 0; i < 5; i++) begin
      exp_rec[i] = mkRec(1'b0, 3'd5, 7'(i + 3), 2'(i + 1));
      runCompletion(3'd5, 7'(50 + 10 * i), 7'(i + 3), 2'(i + 1), i == 4);
      if (i == 3) checkOutput("pp_full_valid", 32'(rec_if.rec_valid), 32'd1);
    end
    checkOutput("pp_head", 32'(rec_if.rec_data), 32'(exp_rec[1]));
    checkOutput("pp_ovf", 32'(overflow), 32'd0);
    checkOutput("pp_count", 32'(comp_count), 32'd5);
    for (int i = 1; i < 3; i++) begin
      checkOutput($sformatf("pp_drain%0d", i), 32'(rec_if.rec_data), 32'(exp_rec[i]));
      waitCycle();
    end
    checkOutput("pp_drain3", 32'(rec_if.rec_data), 32'(exp_rec[3]));

    // Reset mid-drain clears outputs without waiting for a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_valid", 32'(rec_if.rec_valid), 32'd0);
    checkOutput("async_count", 32'(comp_count), 32'd0);
    checkOutput("async_data", 32'(rec_if.rec_data), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    rec_if.rec_ready = 1'b0;
    waitCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
